// File: rtl/sw_sweep_checker.sv
// Sweeps every IN_W-bit stimulus pattern, samples the response SETTLE cycles later, folds it into a 16-bit MISR.
// Latency SETTLE+1 cycles per pattern, done 2^IN_W*(SETTLE+1) cycles after start; start ignored while busy.
module sw_sweep_checker #(
  parameter int IN_W   = 7,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OUT_W-1:0] resp,
  output logic [IN_W-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sig,
  output logic [IN_W:0]    hit_cnt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] ctr;
  logic [15:0]   resp_ext;
  logic          fb;

  assign resp_ext = 16'(resp);
  assign fb       = sig[15] ^ sig[14] ^ sig[12] ^ sig[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      stim    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sig     <= '0;
      hit_cnt <= '0;
      ctr     <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state   <= DRIVE;
            stim    <= '0;
            sig     <= '0;
            hit_cnt <= '0;
            ctr     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        DRIVE: begin
          // resp is deliberately not looked at while the circuit settles
          if (ctr == CW'(SETTLE - 1)) begin
            state <= SAMPLE;
            ctr   <= '0;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        SAMPLE: begin
          sig     <= {sig[14:0], fb} ^ resp_ext;
          hit_cnt <= hit_cnt + {{IN_W{1'b0}}, resp[0]};
          // terminal test before increment so stim never wraps
          if (&stim) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            stim  <= stim + 1'b1;
            state <= DRIVE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_sweep_checker.sv
// Directed bench for sw_sweep_checker: table of sweep runs with a reference MISR, plus reset/restart sequences.
module tb_sw_sweep_checker;

  localparam int IN_W   = 7;
  localparam int OUT_W  = 2;
  localparam int SETTLE = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [OUT_W-1:0] resp;
  logic [IN_W-1:0]  stim;
  logic             busy;
  logic             done;
  logic [15:0]      sig;
  logic [IN_W:0]    hit_cnt;

  int               mode;
  logic [1:0]       glitch;
  int               errors;
  int               checks;

  sw_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .resp    (resp),
    .stim    (stim),
    .busy    (busy),
    .done    (done),
    .sig     (sig),
    .hit_cnt (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lab circuit stand-in; mode 4 value is what appears at the sampling cycle
  function automatic logic [1:0] cut(input int m, input logic [IN_W-1:0] s);
    case (m)
      1:       cut = {1'b0, s[0]};
      2:       cut = 2'b11;
      3:       cut = {s[1] ^ s[3], s[0] ^ s[6]};
      default: cut = 2'b00;
    endcase
  endfunction

  always_comb begin
    resp = cut(mode, stim);
    if (mode == 4) resp = glitch;
  end

  function automatic logic [15:0] misr_model(input int m);
    logic [15:0] s;
    logic [1:0]  r;
    logic        f;
    s = '0;
    for (int p = 0; p < (1 << IN_W); p++) begin
      r = cut(m, p[IN_W-1:0]);
      f = s[15] ^ s[14] ^ s[12] ^ s[3];
      s = {s[14:0], f} ^ {14'b0, r};
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          m;
    logic [7:0]  exp_hit;
    logic [15:0] exp_sig;
    logic        repulse;
  } vec_t;

  vec_t vecs[6];

  // One sweep: pulse start, track the pattern phase, wait for done with a bound
  task automatic run_sweep(input vec_t v);
    int  n;
    bit  seen;
    logic [15:0] sig_done;
    mode = v.m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("sig_cleared", sig, 0);
    check("hit_cleared", hit_cnt, 0);
    glitch = 2'($urandom_range(0, 3));
    n    = 0;
    seen = 0;
    while (n < 2000 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (done) begin
        seen = 1;
      end else begin
        glitch = ((n % (SETTLE + 1)) == SETTLE) ? 2'b00 : 2'($urandom_range(0, 3));
        if (v.repulse && stim == 7'd10 && busy) start = 1'b1;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    // cycle t+1 is the one right after the start edge
    check("done_cycle", n + 1, 641);
    check("busy_at_done", busy, 0);
    check("sig_final", sig, v.exp_sig);
    check("hit_final", hit_cnt, v.exp_hit);
    check("stim_at_done", stim, 7'h7f);
    sig_done = sig;
    repeat (3) @(posedge clk);
    #1;
    check("done_held", done, 1);
    check("sig_held", sig, sig_done);
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;
    mode   = 0;
    glitch = 2'b00;
    start  = 1'b0;
    reset  = 1'b1;

    vecs[0] = '{m: 0, exp_hit: 8'd0,   exp_sig: 16'h0000,      repulse: 1'b0};
    vecs[1] = '{m: 1, exp_hit: 8'd64,  exp_sig: misr_model(1), repulse: 1'b1};
    vecs[2] = '{m: 2, exp_hit: 8'd128, exp_sig: misr_model(2), repulse: 1'b0};
    vecs[3] = '{m: 2, exp_hit: 8'd128, exp_sig: misr_model(2), repulse: 1'b0};
    vecs[4] = '{m: 3, exp_hit: 8'd64,  exp_sig: misr_model(3), repulse: 1'b0};
    vecs[5] = '{m: 4, exp_hit: 8'd0,   exp_sig: 16'h0000,      repulse: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_stim", stim, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sig", sig, 0);
    check("rst_hit", hit_cnt, 0);

    for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

    // Abort mid-sweep at pattern 37
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 1000 && stim != 7'd37) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_stim37", stim, 37);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_stim", stim, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sig", sig, 0);
    check("abort_hit", hit_cnt, 0);
    repeat (SETTLE + 2) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);

    // Fresh sweep from IDLE after the abort
    run_sweep(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
